// File: rtl/nasti_mux_n_if.sv
// NASTI channel bundle with N_LANE parallel lanes; lane i of every field is packed slot i.
// The master modport drives requests and W data, the slave modport drives ready/responses.
interface nasti_channel #(
  parameter int N_LANE     = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [N_LANE-1:0]                 aw_valid;
  logic [N_LANE-1:0]                 aw_ready;
  logic [N_LANE-1:0][ID_WIDTH-1:0]   aw_id;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0] aw_addr;
  logic [N_LANE-1:0][7:0]            aw_len;
  logic [N_LANE-1:0][2:0]            aw_size;
  logic [N_LANE-1:0][1:0]            aw_burst;
  logic [N_LANE-1:0][2:0]            aw_prot;
  logic [N_LANE-1:0][USER_WIDTH-1:0] aw_user;

  logic [N_LANE-1:0]                 w_valid;
  logic [N_LANE-1:0]                 w_ready;
  logic [N_LANE-1:0][DATA_WIDTH-1:0] w_data;
  logic [N_LANE-1:0][STRB_WIDTH-1:0] w_strb;
  logic [N_LANE-1:0]                 w_last;
  logic [N_LANE-1:0][USER_WIDTH-1:0] w_user;

  logic [N_LANE-1:0]                 b_valid;
  logic [N_LANE-1:0]                 b_ready;
  logic [N_LANE-1:0][ID_WIDTH-1:0]   b_id;
  logic [N_LANE-1:0][1:0]            b_resp;
  logic [N_LANE-1:0][USER_WIDTH-1:0] b_user;

  logic [N_LANE-1:0]                 ar_valid;
  logic [N_LANE-1:0]                 ar_ready;
  logic [N_LANE-1:0][ID_WIDTH-1:0]   ar_id;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0] ar_addr;
  logic [N_LANE-1:0][7:0]            ar_len;
  logic [N_LANE-1:0][2:0]            ar_size;
  logic [N_LANE-1:0][1:0]            ar_burst;
  logic [N_LANE-1:0][2:0]            ar_prot;
  logic [N_LANE-1:0][USER_WIDTH-1:0] ar_user;

  logic [N_LANE-1:0]                 r_valid;
  logic [N_LANE-1:0]                 r_ready;
  logic [N_LANE-1:0][ID_WIDTH-1:0]   r_id;
  logic [N_LANE-1:0][DATA_WIDTH-1:0] r_data;
  logic [N_LANE-1:0][1:0]            r_resp;
  logic [N_LANE-1:0]                 r_last;
  logic [N_LANE-1:0][USER_WIDTH-1:0] r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mux_n.sv
// N-to-1 NASTI mux: AW/AR arbitration, W locked to the AW winner, B/R routed back by ID.
// Define NASTI_MUX_FIXED_PRIO_EN for fixed lowest-port-wins arbitration instead of round robin.
//
// state     | meaning
// AW_IDLE   | AW winner forwarded downstream, W blocked
// AW_LOCKED | AW blocked, W beats pass only from lock_port_q until w_last
module nasti_mux_n #(
  parameter int N_PORT     = 4,
  parameter int W_MAX      = 2,
  parameter int R_MAX      = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic          clk,
  input  logic          rstn,
  nasti_channel.slave   s,
  nasti_channel.master  m,
  output logic          resp_err
);
  localparam int PW  = $clog2(N_PORT);
  localparam int WIW = (W_MAX > 1) ? $clog2(W_MAX) : 1;
  localparam int RIW = (R_MAX > 1) ? $clog2(R_MAX) : 1;

  typedef enum logic {AW_IDLE, AW_LOCKED} aw_state_t;

  aw_state_t aw_state_q, aw_state_d;
  logic [PW-1:0] lock_port_q, lock_port_d;

  logic [W_MAX-1:0]               wt_vld_q;
  logic [W_MAX-1:0][ID_WIDTH-1:0] wt_id_q;
  logic [W_MAX-1:0][PW-1:0]       wt_port_q;
  logic [R_MAX-1:0]               rt_vld_q;
  logic [R_MAX-1:0][ID_WIDTH-1:0] rt_id_q;
  logic [R_MAX-1:0][PW-1:0]       rt_port_q;

  logic [N_PORT-1:0] aw_elig, ar_elig;
  logic [PW-1:0]     aw_start, ar_start;
  logic [PW:0]       aw_pick, ar_pick;
  logic              aw_hold_q, ar_hold_q;
  logic [PW-1:0]     aw_hold_port_q, ar_hold_port_q;
  logic              aw_req, ar_req, aw_hs, ar_hs, w_hs;
  logic [PW-1:0]     aw_win, ar_win;

  logic [WIW-1:0] wt_alloc, b_idx;
  logic [RIW-1:0] rt_alloc, r_idx;
  logic           b_hit, r_hit, b_hs, r_hs;
  logic [PW-1:0]  b_port, r_port;

  function automatic logic [PW:0] rr_pick(input logic [N_PORT-1:0] req,
                                          input logic [PW-1:0]     start);
    logic          hit;
    logic [PW-1:0] idx;
    int            k;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N_PORT; i++) begin
      k = (int'(start) + i) % N_PORT;
      if (!hit && req[k]) begin
        hit = 1'b1;
        idx = PW'(k);
      end
    end
    return {hit, idx};
  endfunction

  // A request is eligible only with a free slot and no live entry of the same ID from another port
  always_comb begin
    aw_elig = '0;
    ar_elig = '0;
    for (int p = 0; p < N_PORT; p++) begin
      aw_elig[p] = s.aw_valid[p] && !(&wt_vld_q);
      ar_elig[p] = s.ar_valid[p] && !(&rt_vld_q);
      for (int e = 0; e < W_MAX; e++)
        if (wt_vld_q[e] && wt_id_q[e] == s.aw_id[p] && wt_port_q[e] != PW'(p))
          aw_elig[p] = 1'b0;
      for (int e = 0; e < R_MAX; e++)
        if (rt_vld_q[e] && rt_id_q[e] == s.ar_id[p] && rt_port_q[e] != PW'(p))
          ar_elig[p] = 1'b0;
    end
  end

`ifdef NASTI_MUX_FIXED_PRIO_EN
  assign aw_start = '0;
  assign ar_start = '0;
`else
  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (int'(p) == N_PORT - 1) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0] aw_ptr_q, ar_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_ptr_q <= '0;
      ar_ptr_q <= '0;
    end else begin
      if (aw_hs) aw_ptr_q <= next_port(aw_win);
      if (ar_hs) ar_ptr_q <= next_port(ar_win);
    end
  end

  assign aw_start = aw_ptr_q;
  assign ar_start = ar_ptr_q;
`endif

  // A pending grant is held until its handshake so the forwarded payload stays stable
  always_comb begin
    aw_pick = rr_pick(aw_elig, aw_start);
    ar_pick = rr_pick(ar_elig, ar_start);
    if (aw_hold_q) begin
      aw_req = s.aw_valid[aw_hold_port_q];
      aw_win = aw_hold_port_q;
    end else begin
      aw_req = aw_pick[PW];
      aw_win = aw_pick[PW-1:0];
    end
    if (ar_hold_q) begin
      ar_req = s.ar_valid[ar_hold_port_q];
      ar_win = ar_hold_port_q;
    end else begin
      ar_req = ar_pick[PW];
      ar_win = ar_pick[PW-1:0];
    end
  end

  assign aw_hs = rstn && aw_state_q == AW_IDLE && aw_req && m.aw_ready[0];
  assign ar_hs = rstn && ar_req && m.ar_ready[0];
  assign w_hs  = rstn && aw_state_q == AW_LOCKED && s.w_valid[lock_port_q] && m.w_ready[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_state_q     <= AW_IDLE;
      lock_port_q    <= '0;
      aw_hold_q      <= 1'b0;
      aw_hold_port_q <= '0;
      ar_hold_q      <= 1'b0;
      ar_hold_port_q <= '0;
    end else begin
      aw_state_q     <= aw_state_d;
      lock_port_q    <= lock_port_d;
      aw_hold_q      <= aw_state_q == AW_IDLE && aw_req && !m.aw_ready[0];
      aw_hold_port_q <= aw_win;
      ar_hold_q      <= ar_req && !m.ar_ready[0];
      ar_hold_port_q <= ar_win;
    end
  end

  always_comb begin
    aw_state_d  = aw_state_q;
    lock_port_d = lock_port_q;
    m.aw_valid  = '0;
    s.aw_ready  = '0;
    m.w_valid   = '0;
    s.w_ready   = '0;
    case (aw_state_q)
      AW_IDLE: begin
        m.aw_valid[0]      = rstn && aw_req;
        s.aw_ready[aw_win] = rstn && aw_req && m.aw_ready[0];
        if (aw_hs) begin
          aw_state_d  = AW_LOCKED;
          lock_port_d = aw_win;
        end
      end
      AW_LOCKED: begin
        m.w_valid[0]           = rstn && s.w_valid[lock_port_q];
        s.w_ready[lock_port_q] = rstn && m.w_ready[0];
        if (w_hs && s.w_last[lock_port_q])
          aw_state_d = AW_IDLE;
      end
      default: aw_state_d = AW_IDLE;
    endcase
  end

  always_comb begin
    m.ar_valid         = '0;
    s.ar_ready         = '0;
    m.ar_valid[0]      = rstn && ar_req;
    s.ar_ready[ar_win] = rstn && ar_req && m.ar_ready[0];
  end

  assign m.aw_id[0]    = s.aw_id[aw_win];
  assign m.aw_addr[0]  = s.aw_addr[aw_win];
  assign m.aw_len[0]   = s.aw_len[aw_win];
  assign m.aw_size[0]  = s.aw_size[aw_win];
  assign m.aw_burst[0] = s.aw_burst[aw_win];
  assign m.aw_prot[0]  = s.aw_prot[aw_win];
  assign m.aw_user[0]  = s.aw_user[aw_win];
  assign m.w_data[0]   = s.w_data[lock_port_q];
  assign m.w_strb[0]   = s.w_strb[lock_port_q];
  assign m.w_last[0]   = s.w_last[lock_port_q];
  assign m.w_user[0]   = s.w_user[lock_port_q];
  assign m.ar_id[0]    = s.ar_id[ar_win];
  assign m.ar_addr[0]  = s.ar_addr[ar_win];
  assign m.ar_len[0]   = s.ar_len[ar_win];
  assign m.ar_size[0]  = s.ar_size[ar_win];
  assign m.ar_burst[0] = s.ar_burst[ar_win];
  assign m.ar_prot[0]  = s.ar_prot[ar_win];
  assign m.ar_user[0]  = s.ar_user[ar_win];

  // Descending scans leave the lowest qualifying index as the result
  always_comb begin
    wt_alloc = '0;
    b_hit    = 1'b0;
    b_idx    = '0;
    for (int e = W_MAX - 1; e >= 0; e--) begin
      if (!wt_vld_q[e]) wt_alloc = WIW'(e);
      if (wt_vld_q[e] && wt_id_q[e] == m.b_id[0]) begin
        b_hit = 1'b1;
        b_idx = WIW'(e);
      end
    end
    rt_alloc = '0;
    r_hit    = 1'b0;
    r_idx    = '0;
    for (int e = R_MAX - 1; e >= 0; e--) begin
      if (!rt_vld_q[e]) rt_alloc = RIW'(e);
      if (rt_vld_q[e] && rt_id_q[e] == m.r_id[0]) begin
        r_hit = 1'b1;
        r_idx = RIW'(e);
      end
    end
  end

  assign b_port = wt_port_q[b_idx];
  assign r_port = rt_port_q[r_idx];
  assign b_hs   = rstn && m.b_valid[0] && b_hit && s.b_ready[b_port];
  assign r_hs   = rstn && m.r_valid[0] && r_hit && s.r_ready[r_port];

  // Allocation picks from pre-update valid bits; a same-cycle free lands in a different slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wt_vld_q  <= '0;
      wt_id_q   <= '0;
      wt_port_q <= '0;
    end else begin
      if (b_hs) wt_vld_q[b_idx] <= 1'b0;
      if (aw_hs) begin
        wt_vld_q[wt_alloc]  <= 1'b1;
        wt_id_q[wt_alloc]   <= s.aw_id[aw_win];
        wt_port_q[wt_alloc] <= aw_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rt_vld_q  <= '0;
      rt_id_q   <= '0;
      rt_port_q <= '0;
    end else begin
      if (r_hs && m.r_last[0]) rt_vld_q[r_idx] <= 1'b0;
      if (ar_hs) begin
        rt_vld_q[rt_alloc]  <= 1'b1;
        rt_id_q[rt_alloc]   <= s.ar_id[ar_win];
        rt_port_q[rt_alloc] <= ar_win;
      end
    end
  end

  // Unmatched responses are sunk with ready=1 and never reach an upstream lane
  always_comb begin
    s.b_valid = '0;
    s.r_valid = '0;
    for (int p = 0; p < N_PORT; p++) begin
      s.b_id[p]   = m.b_id[0];
      s.b_resp[p] = m.b_resp[0];
      s.b_user[p] = m.b_user[0];
      s.r_id[p]   = m.r_id[0];
      s.r_data[p] = m.r_data[0];
      s.r_resp[p] = m.r_resp[0];
      s.r_last[p] = m.r_last[0];
      s.r_user[p] = m.r_user[0];
    end
    if (b_hit) s.b_valid[b_port] = rstn && m.b_valid[0];
    if (r_hit) s.r_valid[r_port] = rstn && m.r_valid[0];
    m.b_ready    = '0;
    m.r_ready    = '0;
    m.b_ready[0] = rstn && (b_hit ? s.b_ready[b_port] : 1'b1);
    m.r_ready[0] = rstn && (r_hit ? s.r_ready[r_port] : 1'b1);
  end

  assign resp_err = rstn && ((m.b_valid[0] && !b_hit) || (m.r_valid[0] && !r_hit));

endmodule

// File: tb/tb_nasti_mux_n.sv
// Directed bench for nasti_mux_n: write lock, read table limits, ID aliasing,
// unmatched responses, async reset mid-burst and the arbitration mode.
module tb_nasti_mux_n;
  localparam int N_PORT     = 4;
  localparam int W_MAX      = 2;
  localparam int R_MAX      = 2;
  localparam int ID_WIDTH   = 1;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int USER_WIDTH = 1;

`ifdef NASTI_MUX_FIXED_PRIO_EN
  localparam logic [31:0] G1_LANE = 32'h1, G2_LANE = 32'h1;
  localparam logic        D1_ID = 1'b0, D2_ID = 1'b0;
  localparam logic [31:0] D1_LANE = 32'h1, D2_LANE = 32'h1;
`else
  localparam logic [31:0] G1_LANE = 32'h4, G2_LANE = 32'h1;
  localparam logic        D1_ID = 1'b1, D2_ID = 1'b0;
  localparam logic [31:0] D1_LANE = 32'h4, D2_LANE = 32'h1;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic resp_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nasti_channel #(.N_LANE(N_PORT), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                  .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) s_if ();
  nasti_channel #(.N_LANE(1), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                  .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) m_if ();

  nasti_mux_n #(.N_PORT(N_PORT), .W_MAX(W_MAX), .R_MAX(R_MAX), .ID_WIDTH(ID_WIDTH),
                .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                .USER_WIDTH(USER_WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s        (s_if),
    .m        (m_if),
    .resp_err (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_if.aw_valid = '0; s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0;
    s_if.aw_size = '0; s_if.aw_burst = '0; s_if.aw_prot = '0; s_if.aw_user = '0;
    s_if.w_valid = '0; s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = '0;
    s_if.w_user = '0; s_if.b_ready = '0;
    s_if.ar_valid = '0; s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0;
    s_if.ar_size = '0; s_if.ar_burst = '0; s_if.ar_prot = '0; s_if.ar_user = '0;
    s_if.r_ready = '0;
    m_if.aw_ready = '0; m_if.w_ready = '0; m_if.ar_ready = '0;
    m_if.b_valid = '0; m_if.b_id = '0; m_if.b_resp = '0; m_if.b_user = '0;
    m_if.r_valid = '0; m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0;
    m_if.r_last = '0; m_if.r_user = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset: every outward valid/ready low even with upstream activity
    rstn = 1'b0;
    clear_inputs();
    s_if.aw_valid = 4'hF;
    s_if.ar_valid = 4'hF;
    m_if.aw_ready = 1'b1;
    m_if.b_valid  = 1'b1;
    #2;
    chk("rst_m_aw_valid", 32'(m_if.aw_valid), 32'h0);
    chk("rst_m_ar_valid", 32'(m_if.ar_valid), 32'h0);
    chk("rst_m_w_valid",  32'(m_if.w_valid),  32'h0);
    chk("rst_s_aw_ready", 32'(s_if.aw_ready), 32'h0);
    chk("rst_m_b_ready",  32'(m_if.b_ready),  32'h0);
    chk("rst_m_r_ready",  32'(m_if.r_ready),  32'h0);
    chk("rst_s_b_valid",  32'(s_if.b_valid),  32'h0);
    chk("rst_resp_err",   32'(resp_err),      32'h0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();

    // port 2 write id=1 len=3
    s_if.aw_valid[2] = 1'b1; s_if.aw_id[2] = 1'b1;
    s_if.aw_addr[2]  = 8'h40; s_if.aw_len[2] = 8'd3;
    m_if.aw_ready = 1'b1;
    #1;
    chk("aw_pass_valid", 32'(m_if.aw_valid), 32'h1);
    chk("aw_pass_addr",  32'(m_if.aw_addr[0]), 32'h40);
    chk("aw_pass_len",   32'(m_if.aw_len[0]), 32'h3);
    chk("aw_ready_lane", 32'(s_if.aw_ready), 32'h4);
    tick();
    s_if.aw_valid[2] = 1'b0;
    s_if.aw_valid[0] = 1'b1;
    s_if.w_valid[1]  = 1'b1; s_if.w_data[1] = 8'hEE;
    m_if.w_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_if.w_valid[2] = 1'b1;
      s_if.w_data[2]  = 8'(8'hA0 + b);
      s_if.w_last[2]  = (b == 3);
      if (b == 3) s_if.aw_valid[0] = 1'b0;
      #1;
      chk("locked_aw_off", 32'(m_if.aw_valid), 32'h0);
      chk("w_pass_valid",  32'(m_if.w_valid), 32'h1);
      chk("w_pass_data",   32'(m_if.w_data[0]), 32'(8'hA0 + b));
      chk("w_ready_lane",  32'(s_if.w_ready), 32'h4);
      chk("w_pass_last",   32'(m_if.w_last), 32'(b == 3));
      tick();
    end
    s_if.w_valid[2] = 1'b0; s_if.w_last[2] = 1'b0;
    #1;
    chk("idle_w_blocked", 32'(m_if.w_valid), 32'h0);
    chk("idle_w_ready",   32'(s_if.w_ready), 32'h0);
    s_if.w_valid[1] = 1'b0;
    s_if.b_ready = 4'hF;
    m_if.b_valid = 1'b1; m_if.b_id = 1'b1;
    #1;
    chk("b_route_lane", 32'(s_if.b_valid), 32'h4);
    chk("b_route_rdy",  32'(m_if.b_ready), 32'h1);
    chk("b_route_err",  32'(resp_err), 32'h0);
    tick();
    chk("b_freed_err",   32'(resp_err), 32'h1);
    chk("b_freed_lane",  32'(s_if.b_valid), 32'h0);
    chk("b_freed_ready", 32'(m_if.b_ready), 32'h1);
    tick();
    m_if.b_valid = 1'b0;
    #1;
    chk("b_err_drop", 32'(resp_err), 32'h0);
    tick();

`ifndef NASTI_MUX_FIXED_PRIO_EN
    // ports 0 (id 0) and 1 (id 1) read continuously, two-entry table
    m_if.ar_ready = 1'b1;
    s_if.r_ready  = 4'hF;
    s_if.ar_valid = 4'b0011; s_if.ar_id[0] = 1'b0; s_if.ar_id[1] = 1'b1;
    #1;
    chk("ar_g0_lane", 32'(s_if.ar_ready), 32'h1);
    chk("ar_g0_id",   32'(m_if.ar_id[0]), 32'h0);
    tick();
    chk("ar_g1_lane", 32'(s_if.ar_ready), 32'h2);
    chk("ar_g1_id",   32'(m_if.ar_id[0]), 32'h1);
    tick();
    chk("ar_full_valid", 32'(m_if.ar_valid), 32'h0);
    chk("ar_full_ready", 32'(s_if.ar_ready), 32'h0);
    m_if.r_valid = 1'b1; m_if.r_id = 1'b0; m_if.r_last = 1'b0;
    #1;
    chk("r_nonlast_lane", 32'(s_if.r_valid), 32'h1);
    tick();
    chk("r_nonlast_keeps", 32'(m_if.ar_valid), 32'h0);
    m_if.r_last = 1'b1;
    #1;
    chk("r_last_lane",   32'(s_if.r_valid), 32'h1);
    chk("ar_free_bubble", 32'(m_if.ar_valid), 32'h0);
    tick();
    m_if.r_valid = 1'b0;
    #1;
    chk("ar_g2_lane", 32'(s_if.ar_ready), 32'h1);
    tick();
    m_if.r_valid = 1'b1; m_if.r_id = 1'b1; m_if.r_last = 1'b1;
    #1;
    chk("r_id1_lane", 32'(s_if.r_valid), 32'h2);
    tick();
    m_if.r_valid = 1'b0;
    #1;
    chk("ar_g3_lane", 32'(s_if.ar_ready), 32'h2);
    tick();
    s_if.ar_valid = '0;
    m_if.r_valid = 1'b1; m_if.r_id = 1'b0; m_if.r_last = 1'b1;
    #1;
    chk("r_drain0_lane", 32'(s_if.r_valid), 32'h1);
    tick();
    m_if.r_id = 1'b1;
    #1;
    chk("r_drain1_lane", 32'(s_if.r_valid), 32'h2);
    tick();
    m_if.r_valid = 1'b0;
`endif

    // ports 0 (id 0) and 2 (id 1) read: arbitration mode decides the winners
    m_if.ar_ready = 1'b1;
    s_if.r_ready  = 4'hF;
    s_if.ar_valid = 4'b0101; s_if.ar_id[0] = 1'b0; s_if.ar_id[2] = 1'b1;
    #1;
    chk("arb_g1_lane", 32'(s_if.ar_ready), G1_LANE);
    tick();
    chk("arb_g2_lane", 32'(s_if.ar_ready), G2_LANE);
    tick();
    chk("arb_full", 32'(m_if.ar_valid), 32'h0);
    s_if.ar_valid = '0;
    m_if.r_valid = 1'b1; m_if.r_id = D1_ID; m_if.r_last = 1'b1;
    #1;
    chk("arb_drain1", 32'(s_if.r_valid), D1_LANE);
    tick();
    m_if.r_id = D2_ID;
    #1;
    chk("arb_drain2", 32'(s_if.r_valid), D2_LANE);
    tick();
    m_if.r_valid = 1'b0; m_if.r_last = 1'b0;

    // port 0 AW id=0 with w_last in the same cycle: lock wins
    s_if.aw_valid[0] = 1'b1; s_if.aw_id[0] = 1'b0;
    s_if.w_valid[0] = 1'b1; s_if.w_last[0] = 1'b1; s_if.w_data[0] = 8'h11;
    #1;
    chk("aw_p0_lane",   32'(s_if.aw_ready), 32'h1);
    chk("same_cyc_wrdy", 32'(s_if.w_ready), 32'h0);
    chk("same_cyc_wval", 32'(m_if.w_valid), 32'h0);
    tick();
    s_if.aw_valid[0] = 1'b0;
    #1;
    chk("p0_w_valid", 32'(m_if.w_valid), 32'h1);
    chk("p0_w_ready", 32'(s_if.w_ready), 32'h1);
    tick();
    s_if.w_valid[0] = 1'b0; s_if.w_last[0] = 1'b0;
    s_if.aw_valid[3] = 1'b1; s_if.aw_id[3] = 1'b0;
    #1;
    chk("alias_block_v", 32'(m_if.aw_valid), 32'h0);
    chk("alias_block_r", 32'(s_if.aw_ready), 32'h0);
    s_if.aw_valid[0] = 1'b1;
    #1;
    chk("same_port_ok", 32'(s_if.aw_ready), 32'h1);
    tick();
    s_if.aw_valid[0] = 1'b0;
    s_if.w_valid[0] = 1'b1; s_if.w_last[0] = 1'b1;
    #1;
    chk("p0_w2_ready", 32'(s_if.w_ready), 32'h1);
    tick();
    s_if.w_valid[0] = 1'b0; s_if.w_last[0] = 1'b0;
    #1;
    chk("alias_still", 32'(m_if.aw_valid), 32'h0);
    m_if.b_valid = 1'b1; m_if.b_id = 1'b0;
    #1;
    chk("b0_first_lane", 32'(s_if.b_valid), 32'h1);
    chk("b0_first_aw",   32'(m_if.aw_valid), 32'h0);
    tick();
    chk("b0_second_lane", 32'(s_if.b_valid), 32'h1);
    chk("b0_second_aw",   32'(m_if.aw_valid), 32'h0);
    tick();
    m_if.b_valid = 1'b0;
    #1;
    chk("alias_release", 32'(s_if.aw_ready), 32'h8);
    tick();
    s_if.aw_valid[3] = 1'b0;
    s_if.w_valid[3] = 1'b1; s_if.w_last[3] = 1'b1;
    #1;
    chk("p3_w_ready", 32'(s_if.w_ready), 32'h8);
    tick();
    s_if.w_valid[3] = 1'b0; s_if.w_last[3] = 1'b0;
    m_if.b_valid = 1'b1; m_if.b_id = 1'b0;
    #1;
    chk("b_p3_lane", 32'(s_if.b_valid), 32'h8);
    tick();
    m_if.b_valid = 1'b0;

    // unmatched read response is sunk
    s_if.r_ready = '0;
    m_if.r_valid = 1'b1; m_if.r_id = 1'b1; m_if.r_last = 1'b1;
    #1;
    chk("r_unm_ready", 32'(m_if.r_ready), 32'h1);
    chk("r_unm_err",   32'(resp_err), 32'h1);
    chk("r_unm_lanes", 32'(s_if.r_valid), 32'h0);
    tick();
    m_if.r_valid = 1'b0;
    #1;
    chk("r_unm_pulse", 32'(resp_err), 32'h0);

    // async reset during W beat 2 of 4
    s_if.aw_valid[2] = 1'b1; s_if.aw_id[2] = 1'b1; s_if.aw_len[2] = 8'd3;
    #1;
    chk("rst_aw_lane", 32'(s_if.aw_ready), 32'h4);
    tick();
    s_if.aw_valid[2] = 1'b0;
    s_if.w_valid[2] = 1'b1; s_if.w_last[2] = 1'b0;
    #1;
    chk("rst_beat1", 32'(s_if.w_ready), 32'h4);
    tick();
    chk("rst_beat2", 32'(s_if.w_ready), 32'h4);
    rstn = 1'b0;
    #1;
    chk("rst_mid_wrdy", 32'(s_if.w_ready), 32'h0);
    chk("rst_mid_wval", 32'(m_if.w_valid), 32'h0);
    rstn = 1'b1;
    #1;
    chk("rst_lock_gone", 32'(m_if.w_valid), 32'h0);
    s_if.w_valid[2] = 1'b0;
    m_if.b_valid = 1'b1; m_if.b_id = 1'b1;
    #1;
    chk("rst_abandon_err", 32'(resp_err), 32'h1);
    m_if.b_valid = 1'b0;
    s_if.aw_valid[1] = 1'b1; s_if.aw_id[1] = 1'b1;
    #1;
    chk("post_rst_aw", 32'(s_if.aw_ready), 32'h2);
    tick();
    s_if.aw_valid[1] = 1'b0;
    s_if.w_valid[1] = 1'b1; s_if.w_last[1] = 1'b1; s_if.w_data[1] = 8'h55;
    #1;
    chk("post_rst_wrdy", 32'(s_if.w_ready), 32'h2);
    chk("post_rst_data", 32'(m_if.w_data[0]), 32'h55);
    tick();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nasti_mux_n.md
# nasti_mux_n

Parametrised N-to-1 NASTI multiplexer that merges up to N_PORT upstream masters onto one downstream NASTI port. It sits between the tile/DMA masters and the memory or IO crossbar. It arbitrates AW and AR independently and keeps the W burst locked to the AW winner. It tracks outstanding transactions in bounded tables and routes B and R responses back by ID. Unlike the fixed 8-port predecessor, it has a configurable port count, releases read entries on r_last, blocks cross-port ID aliasing, and flags unmatched responses.

## Interface
- N_PORT, 4, number of upstream ports (2..16)
- W_MAX, 2, outstanding write table depth (≥1)
- R_MAX, 2, outstanding read table depth (≥1)
- ID_WIDTH, 1, transaction ID width
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 8, data width
- USER_WIDTH, 1, user field width (>0)
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- s  nasti_channel.slave  N_PORT lanes  upstream masters, lane i = port i
- m  nasti_channel.master  1 lane  downstream port
- resp_err  output  1  one-cycle pulse when a B or R beat matches no table entry

## Operation
- Reset values:
  - All table entries are invalid; the write lock is 0; both round-robin pointers are 0; resp_err is 0.
  - m.aw_valid, m.w_valid, m.ar_valid, m.b_ready and m.r_ready are 0.
  - All s.*_ready and s.*_valid are 0.
- Each table entry holds {id, port[$clog2(N_PORT)-1:0], valid}.
- An AW/AR request from port p with id x is eligible only if:
  - its table has a free entry, and
  - no valid entry holds id x with a port ≠ p.
- The arbiter chooses among eligible requests only.
- AW path:
  - States are IDLE and LOCKED.
  - In IDLE, the AW winner is forwarded to m.
  - On the m.aw handshake, allocate the lowest free write entry and move to LOCKED on that port.
  - In LOCKED, m.aw_valid is 0. W beats pass only from the locked port, and s.w_ready is asserted only on that lane.
  - On the w_last handshake, return to IDLE.
- AR path: forward the AR winner. On the m.ar handshake, allocate the lowest free read entry.
- B routing:
  - Match m.b_id against the valid write entries; the lowest matching index wins.
  - s.b_valid is raised only on that entry's port. On the b handshake, free that entry.
- R routing:
  - Match m.r_id the same way and raise s.r_valid on the matched port.
  - Free the entry only on a handshake with r_last=1. Non-last beats keep the entry.
- Unmatched B/R beat: m.*_ready=1, which sinks the beat; no s lane sees valid; resp_err pulses.
- Same id from the same port may occupy several entries. The downstream slave's per-ID ordering makes them interchangeable.

## Timing
- AW, AR and W are combinational pass-through: zero cycles from s valid to m valid once granted.
- The grant is held while the chosen valid is high without ready, so payload stays stable per NASTI.
- The round-robin pointer advances to winner+1 only on a handshake.
- B and R return paths are combinational: m.valid reaches s.valid on the matched lane in the same cycle.
- When the AW handshake and w_last happen in the same cycle, the lock is set, not cleared. A W beat only counts when LOCKED.
- Allocate and free in the same cycle, same table:
  - Both take effect.
  - Free-slot selection uses pre-update valid bits, so a full table allows no allocation that cycle (one-cycle bubble).
- Asynchronous reset mid-burst clears all state immediately. Outstanding transactions are abandoned, and later responses for them raise resp_err.

## Configuration
- NASTI_MUX_FIXED_PRIO_EN:
  - When defined, AW and AR arbitration is fixed priority, with the lowest eligible port index winning, and no pointer state exists.
  - When undefined, round-robin arbitration is used as described above.

## Test plan
- Reset, then port 2 issues AW id=1 len=3 -> m.aw_valid in the same cycle; W locked to port 2 for 4 beats; B id=1 -> s.b_valid only on lane 2; write entry freed.
- Ports 0 and 1 both issue AR continuously, R_MAX=2 -> grants alternate 0,1,0,1. A third AR is stalled until an r_last handshake frees an entry; non-last R beats do not free.
- Port 0 has write id=0 outstanding; port 3 issues AW id=0 -> port 3 is blocked until port 0's B completes. A port 0 AW id=0 proceeds if a slot is free.
- m.r_valid with id=1 while no read entry holds id 1 -> m.r_ready=1, resp_err=1 for one cycle, all s.r_valid=0.
- Assert rstn=0 during W beat 2 of 4 -> lock clears, all s.*_ready=0 immediately; after release, new AW from port 1 is accepted normally.
- With NASTI_MUX_FIXED_PRIO_EN defined, ports 0 and 2 continuously request -> port 0 always wins while eligible.
